// File: rtl/uart_cfg_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the UART/VGA configuration-bus arbiter.
package uart_cfg_arbiter_pkg;

  localparam int DEF_N_REQ             = 2;
  localparam int DEF_WIDTH_CONFIG_ADDR = 2;
  localparam int DEF_WIDTH_CONFIG_DATA = 8;
  localparam int DEF_BUSY_TIMEOUT      = 16;

  localparam logic [1:0] CFG_ADDR_UART = 2'b01;
  localparam logic [1:0] CFG_ADDR_VGA  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_FREE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cfg_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping to 0.
module uart_cfg_arbiter_rr_picker
  import uart_cfg_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(ptr) + 32'(k)) % 32'(N_REQ));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_cfg_arbiter.sv
// Shares the UART/VGA config bus among N_REQ requesters: grant, one c_valid strobe,
// wait for the target to go busy then free (or time out), then a one-cycle ack.
module uart_cfg_arbiter
  import uart_cfg_arbiter_pkg::*;
#(
  parameter int N_REQ             = DEF_N_REQ,
  parameter int WIDTH_CONFIG_ADDR = DEF_WIDTH_CONFIG_ADDR,
  parameter int WIDTH_CONFIG_DATA = DEF_WIDTH_CONFIG_DATA,
  parameter int BUSY_TIMEOUT      = DEF_BUSY_TIMEOUT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ*WIDTH_CONFIG_ADDR-1:0]   req_addr,
  input  logic [N_REQ*WIDTH_CONFIG_DATA-1:0]   req_data,
  output logic [N_REQ-1:0]                     req_ack,
  output logic                                 req_timeout,
  output logic [WIDTH_CONFIG_ADDR-1:0]         c_addr,
  output logic                                 c_valid,
  output logic [WIDTH_CONFIG_DATA-1:0]         c_data,
  input  logic                                 c_ready,
  output logic                                 busy
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  state_t state_q, state_d;

  logic [IW-1:0]    rr_ptr_q, winner_q, pick_idx;
  logic [N_REQ-1:0] winner_oh_q, pick_grant;
  logic             pick_any, grant_now, cnt_hit;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH_CONFIG_ADDR-1:0] pick_addr;
  logic [WIDTH_CONFIG_DATA-1:0] pick_data;

  logic             c_valid_d, busy_d, req_timeout_d;
  logic [N_REQ-1:0] req_ack_d;

  uart_cfg_arbiter_rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A target that is already busy blocks new grants entirely.
  assign grant_now = (state_q == ST_IDLE) && pick_any && !c_ready;
  assign cnt_hit   = (cnt_q + CW'(1)) == CNT_LAST;

  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) begin
        pick_addr = req_addr[i*WIDTH_CONFIG_ADDR +: WIDTH_CONFIG_ADDR];
        pick_data = req_data[i*WIDTH_CONFIG_DATA +: WIDTH_CONFIG_DATA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (grant_now) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (c_ready)      state_d = ST_WAIT_FREE;
        else if (cnt_hit) state_d = ST_DONE;
      end
      ST_WAIT_FREE: if (!c_ready) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they line up with the state.
  always_comb begin
    c_valid_d     = (state_d == ST_ISSUE);
    busy_d        = (state_d != ST_IDLE);
    req_ack_d     = (state_d == ST_DONE) ? winner_oh_q : '0;
    req_timeout_d = (state_q == ST_WAIT_BUSY) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      winner_oh_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_now) begin
          winner_q    <= pick_idx;
          winner_oh_q <= pick_grant;
        end
        ST_ISSUE: begin
          rr_ptr_q <= (winner_q == LAST_IDX) ? '0 : winner_q + IW'(1);
          cnt_q    <= '0;
        end
        ST_WAIT_BUSY: if (!c_ready && !cnt_hit) cnt_q <= cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid     <= 1'b0;
      busy        <= 1'b0;
      req_ack     <= '0;
      req_timeout <= 1'b0;
      c_addr      <= '0;
      c_data      <= '0;
    end else begin
      c_valid     <= c_valid_d;
      busy        <= busy_d;
      req_ack     <= req_ack_d;
      req_timeout <= req_timeout_d;
      // Address/data hold the last granted word until the next grant.
      if (grant_now) begin
        c_addr <= pick_addr;
        c_data <= pick_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Self-checking bench for uart_cfg_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_cfg_arbiter;
  import uart_cfg_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int BT = 16;
  localparam int TGT_HOLD = 3;

  typedef enum int {TGT_MANUAL, TGT_REACT, TGT_DEAD} tgt_mode_t;

  logic        clk, rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_ack;
  logic        req_timeout;
  logic [1:0]  c_addr;
  logic        c_valid;
  logic [7:0]  c_data;
  logic        c_ready;
  logic        busy;

  uart_cfg_arbiter #(
    .N_REQ(N), .WIDTH_CONFIG_ADDR(2), .WIDTH_CONFIG_DATA(8), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ack(req_ack), .req_timeout(req_timeout), .c_addr(c_addr), .c_valid(c_valid),
    .c_data(c_data), .c_ready(c_ready), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Target model: manual level, a reactive target (busy 2 cycles after c_valid, for TGT_HOLD cycles),
  // or a dead target that never goes busy.
  tgt_mode_t tgt_mode;
  logic      man_ready;
  logic      react_ready = 1'b0;
  int        rise_in = 0;
  int        hold_left = 0;

  always @(negedge clk) begin
    if (c_valid) rise_in = 2;
    else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) hold_left = TGT_HOLD;
    end
    react_ready = (hold_left > 0);
    if (hold_left > 0) hold_left--;
  end

  assign c_ready = (tgt_mode == TGT_MANUAL) ? man_ready :
                   (tgt_mode == TGT_REACT)  ? react_ready : 1'b0;

  // Transaction-level model: one outstanding write, described by its issue and done cycles.
  logic       m_active, m_seen_busy, m_timeout;
  int         m_issue, m_done, m_winner, m_ptr;
  logic [1:0] m_addr;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst) begin
    int n, w;
    bit found;
    if (!rst) begin
      m_active = 1'b0; m_seen_busy = 1'b0; m_timeout = 1'b0;
      m_issue = -1; m_done = -1; m_winner = 0; m_ptr = 0;
      m_addr = '0; m_data = '0;
    end else begin
      n = cyc;
      if (m_active) begin
        if (n == m_done) m_active = 1'b0;
        else if (n > m_issue && m_done < 0) begin
          if (!m_seen_busy) begin
            if (c_ready) m_seen_busy = 1'b1;
            else if (n - m_issue == BT - 1) begin
              m_done = n + 1;
              m_timeout = 1'b1;
            end
          end else if (!c_ready) m_done = n + 1;
        end
      end else if (req_valid != 2'b00 && !c_ready) begin
        found = 1'b0;
        w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1'b1;
            w = (m_ptr + k) % N;
          end
        end
        m_winner = w;
        m_ptr = (w + 1) % N;
        m_issue = n + 1;
        m_done = -1;
        m_seen_busy = 1'b0;
        m_timeout = 1'b0;
        m_addr = req_addr[w*2 +: 2];
        m_data = req_data[w*8 +: 8];
        m_active = 1'b1;
      end
    end
  end

  int valid_count = 0;
  int ack_count   = 0;

  always @(negedge clk) begin
    logic [1:0] exp_ack;
    logic       at_done;
    at_done = m_active && (cyc == m_done);
    exp_ack = 2'b00;
    if (at_done) exp_ack[m_winner] = 1'b1;
    check("cmp_c_valid", c_valid, m_active && (cyc == m_issue));
    check("cmp_busy", busy, m_active);
    check("cmp_req_ack", req_ack, exp_ack);
    check("cmp_req_timeout", req_timeout, at_done && m_timeout);
    check("cmp_c_addr", c_addr, m_addr);
    check("cmp_c_data", c_data, m_data);
    if (c_valid) valid_count++;
    if (req_ack != 2'b00) ack_count++;
  end

  task automatic wait_valid(input string name, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (c_valid) begin
        at = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL %s_valid_wait: got no c_valid in 40 cycles, expected one pulse", name);
  endtask

  task automatic wait_ack(input string name, output int idx, output logic to, output int at);
    idx = -1;
    to  = 1'b0;
    at  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ack != 2'b00) begin
        idx = req_ack[1] ? 1 : 0;
        to  = req_timeout;
        at  = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL %s_ack_wait: got no req_ack in 40 cycles, expected one pulse", name);
  endtask

  initial begin
    int   exp_seq [4] = '{0, 1, 0, 1};
    int   idx, at, vt, r, v0, a0;
    logic to;

    rst = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    tgt_mode = TGT_MANUAL;
    man_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, c_valid, req_timeout, req_ack, c_addr, c_data}, 0);
    rst = 1'b1;

    // Contention: both requesters held high for four transactions.
    tgt_mode = TGT_REACT;
    req_addr = {CFG_ADDR_VGA, CFG_ADDR_UART};
    req_data = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      v0 = valid_count;
      wait_ack("contention", idx, to, at);
      check("contention_grant", idx, exp_seq[k]);
      check("contention_one_valid", valid_count - v0, 1);
    end
    req_valid = 2'b00;

    // Single write with a target busy two cycles after c_valid.
    @(negedge clk);
    req_addr = {2'b00, CFG_ADDR_UART};
    req_data = {8'h00, 8'hA5};
    req_valid = 2'b01;
    r = cyc;
    wait_valid("single", vt);
    check("single_issue_latency", vt - r, 1);
    check("single_c_addr", c_addr, CFG_ADDR_UART);
    check("single_c_data", c_data, 8'hA5);
    wait_ack("single", idx, to, at);
    req_valid = 2'b00;
    check("single_ack_idx", idx, 0);
    check("single_timeout", to, 0);
    check("single_ack_after_valid", at - vt, 6);
    check("single_ack_after_req", at - r, 7);

    // Timeout: the target never goes busy.
    @(negedge clk);
    tgt_mode = TGT_DEAD;
    req_addr = {CFG_ADDR_VGA, 2'b00};
    req_data = {8'h3C, 8'h00};
    req_valid = 2'b10;
    wait_valid("timeout", vt);
    check("timeout_c_addr", c_addr, CFG_ADDR_VGA);
    wait_ack("timeout", idx, to, at);
    req_valid = 2'b00;
    check("timeout_ack_idx", idx, 1);
    check("timeout_flag", to, 1);
    check("timeout_delay", at - vt, BT);
    @(negedge clk);
    check("timeout_back_idle", busy, 0);

    // Target already busy when the request arrives.
    tgt_mode = TGT_MANUAL;
    man_ready = 1'b1;
    req_data = {8'h7E, 8'h00};
    req_valid = 2'b10;
    v0 = valid_count;
    repeat (10) @(negedge clk);
    check("busy_at_req_no_valid", valid_count - v0, 0);
    man_ready = 1'b0;
    r = cyc;
    wait_valid("busy_at_req", vt);
    check("busy_at_req_latency", vt - r, 1);
    check("busy_at_req_c_data", c_data, 8'h7E);
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
    wait_ack("busy_at_req", idx, to, at);
    req_valid = 2'b00;
    check("busy_at_req_ack_idx", idx, 1);
    check("busy_at_req_timeout", to, 0);

    // Reset in the middle of WAIT_FREE, then the held request is granted again.
    @(negedge clk);
    req_addr = {2'b00, CFG_ADDR_UART};
    req_data = {8'h00, 8'h5A};
    req_valid = 2'b01;
    wait_valid("midop", vt);
    check("midop_c_data", c_data, 8'h5A);
    man_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("midop_busy", busy, 1);
    a0 = ack_count;
    #2 rst = 1'b0;
    #1 check("midop_reset_outputs", {busy, c_valid, req_timeout, req_ack, c_addr, c_data}, 0);
    man_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_no_ack", ack_count - a0, 0);
    rst = 1'b1;
    r = cyc;
    wait_valid("midop_regrant", vt);
    check("midop_regrant_latency", vt - r, 1);
    check("midop_regrant_c_addr", c_addr, CFG_ADDR_UART);
    check("midop_regrant_c_data", c_data, 8'h5A);
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
    wait_ack("midop_regrant", idx, to, at);
    req_valid = 2'b00;
    check("midop_regrant_ack_idx", idx, 0);

    // Requester withdraws after the grant: the write still completes once.
    @(negedge clk);
    tgt_mode = TGT_REACT;
    req_addr = {2'b00, CFG_ADDR_VGA};
    req_data = {8'h00, 8'hC3};
    req_valid = 2'b01;
    v0 = valid_count;
    a0 = ack_count;
    wait_valid("withdraw", vt);
    @(negedge clk);
    req_valid = 2'b00;
    wait_ack("withdraw", idx, to, at);
    check("withdraw_ack_idx", idx, 0);
    check("withdraw_timeout", to, 0);
    check("withdraw_ack_after_valid", at - vt, 6);
    repeat (10) @(negedge clk);
    check("withdraw_one_ack", ack_count - a0, 1);
    check("withdraw_one_valid", valid_count - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got no completion by 100000 time units, expected bench to finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
